// File: rtl/muldiv_unit.sv
// MIPS multiply/divide unit with HI/LO registers: iterative radix-2 shift-add / restoring divide.
// Latency: mul/div result and done pulse appear ITER+1 edges after start; MTHI/MTLO write in one edge.
// Backpressure: start is ignored while busy=1; optional MULDIV_FAST_MUL_EN gives single-cycle MULT/MULTU.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;     // product high half / partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;     // multiplier+product low half / dividend+quotient
    logic [WIDTH-1:0] opb_q, opb_d;     // |multiplicand| or |divisor|
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;     // product/quotient needs negation
    logic             rneg_q, rneg_d;   // remainder needs negation (dividend negative)
    logic             dz_q, dz_d;       // divide by zero
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             a_neg, b_neg;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic [2*WIDTH-1:0] prod;

    // Next-state, datapath step and result fix-up
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        a_neg    = ~op[0] & a[WIDTH-1];
        b_neg    = ~op[0] & b[WIDTH-1];
        sum      = {1'b0, rem_q} + ({1'b0, opb_q} & {(WIDTH+1){quo_q[0]}});
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted[WIDTH-1:0] - opb_q;
`ifdef MULDIV_FAST_MUL_EN
        prod     = is_div_q ? {rem_q, quo_q}
                            : ({{WIDTH{1'b0}}, quo_q} * {{WIDTH{1'b0}}, opb_q});
`else
        prod     = {rem_q, quo_q};
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            // op[0]=0 selects the signed variant; op[1]=1 selects divide
                            quo_d    = a_neg ? -a : a;
                            opb_d    = b_neg ? -b : b;
                            rem_d    = '0;
                            cnt_d    = '0;
                            is_div_d = op[1];
                            neg_d    = a_neg ^ b_neg;
                            rneg_d   = a_neg;
                            dz_d     = op[1] & (b == '0);
`ifdef MULDIV_FAST_MUL_EN
                            state_d  = op[1] ? CALC : FIN;
`else
                            state_d  = CALC;
`endif
                        end
                        3'd4:    hi_d = a;
                        3'd5:    lo_d = a;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (is_div_q) begin
                    // Restoring step: shift in next dividend bit, subtract if it fits
                    if (shifted >= {1'b0, opb_q}) begin
                        rem_d = diff;
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    // Shift-add step: conditionally add, then shift {rem,quo} right
                    rem_d = sum[WIDTH:1];
                    quo_d = {sum[0], quo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) state_d = FIN;
            end
            FIN: begin
                if (is_div_q) begin
                    lo_d = dz_q ? '1 : (neg_q ? -quo_q : quo_q);
                    hi_d = rneg_q ? -rem_q : rem_q;
                end else begin
                    {hi_d, lo_d} = neg_q ? -prod : prod;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the MIPS datapath.
- Serves the operations the single-cycle ALU does not: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Iterative radix-2 engine with a start/busy/done handshake; decode stalls the pipeline while busy=1.
- MFHI/MFLO read the hi/lo outputs directly.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits. Only 32 is required to work.
- ITER, WIDTH, number of iteration cycles per mul/div; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  issue request; sampled only while busy=0
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op
- a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
- b  input  WIDTH  rt operand (multiplier / divisor)
- busy  output  1  high while a mul/div is in progress
- done  output  1  one-cycle pulse on the cycle hi/lo first show a new mul/div result
- hi  output  WIDTH  HI register (product high half / remainder)
- lo  output  WIDTH  LO register (product low half / quotient)

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, busy=0, done=0, hi=0, lo=0, all internal registers cleared. Reset mid-operation aborts the operation and discards it; no done pulse follows.
- States: IDLE, CALC, FIN.
- IDLE, start=1, op in 0..3:
  - latch operands: absolute values for signed ops, raw values for unsigned ops;
  - latch the result signs; clear the counter; busy=1 from this edge; go to CALC.
- IDLE, start=1, op=4/5: hi (or lo) <= a at this edge; busy stays 0; no done pulse; stay in IDLE.
- IDLE, start=1, op=6/7: ignored.
- CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle. After ITER steps go to FIN.
- FIN: apply sign fix-up; write hi/lo; busy=0; done=1 for exactly this cycle; go to IDLE.
- Latency: start sampled at edge E0 → done=1 and new hi/lo visible after edge E0+ITER+1 (33 for WIDTH=32). The latency is fixed, including for zero operands and divide-by-zero.
- start during busy=1 (any op, including MTHI/MTLO): ignored, not queued. The pipeline must hold the request until busy=0.
- start=1 in the same cycle as the FIN transition: busy is still 1 at that edge, so the request is ignored. The requester re-issues next cycle.
- hi/lo keep their old values throughout CALC; they change only at FIN, on MTHI/MTLO, or on reset.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product. MULT negates the product when operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder. DIV truncates toward zero; the quotient is negated if signs differ; the remainder takes the sign of the dividend.
  - 0x80000000 DIV 0xFFFFFFFF: lo=0x80000000, hi=0 (two's-complement wrap, no trap).
  - Divide by zero (DIV or DIVU with b=0): lo=0xFFFFFFFF, hi=a unmodified. Timing is unchanged. No exception is raised.
- Operand inputs are don't-care after the start cycle.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute with a single-cycle combinational multiplier and skip CALC: IDLE → FIN → IDLE.
  - Result and done appear after edge E0+1. busy is high for exactly one cycle.
  - Divide path and latency are unchanged.
- Not defined: all mul/div ops use the iterative path with ITER+1 latency, as above.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 → done exactly 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFFA. With MULTU and the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Under MULDIV_FAST_MUL_EN, done is asserted 1 cycle after start.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: DIVU a=5, b=0 → after 33 cycles lo=0xFFFFFFFF, hi=5, done pulses once.
- Hazards:
  - Start DIVU 100/7; at cycle 5 assert start with MTHI a=0x1234 → MTHI ignored; final hi=2, lo=14.
  - After busy=0, MTHI a=0x1234 → hi=0x1234 next cycle, done stays 0.
- Reset mid-op: start MULT 3*4, assert rst at cycle 10 → next edge busy=0, done=0, hi=lo=0. No done pulse in the following 40 cycles.
